// File: rtl/jt49_seq_pkg.sv
// Shared constants and types for the jt49 command sequencer.
package jt49_seq_pkg;

  localparam int CMD_W = 12;  // {opcode/reg, data}
  localparam int REG_W = 4;   // jt49 register address / opcode field
  localparam int DAT_W = 8;   // jt49 register data / command argument

  localparam logic [REG_W-1:0] OP_END  = 4'hE;
  localparam logic [REG_W-1:0] OP_WAIT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WAIT
  } state_e;

  typedef struct packed {
    logic [REG_W-1:0] addr;
    logic [DAT_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/jt49_seq_wait.sv
// Loadable down-counter for sequencer wait commands; counts cen pulses.
module jt49_seq_wait #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         cen,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: a load wins; otherwise count down on cen, resting at zero.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cen && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for state so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last pulse of the wait: the count is 1 and this cycle's cen consumes it.
  assign expire = cen && (cnt_q == W'(1));

endmodule

// File: rtl/jt49_seq.sv
// Command sequencer/arbiter: plays {addr,data} commands from a synchronous
// ROM onto the jt49 register bus, with a priority CPU write port.
module jt49_seq
  import jt49_seq_pkg::*;
#(
  parameter int AW      = 6,
  parameter int WAIT_SH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             start,
  input  logic             stop,
  output logic [AW-1:0]    rom_addr,
  input  logic [CMD_W-1:0] rom_data,
  input  logic             cpu_wr_n,
  input  logic [REG_W-1:0] cpu_addr,
  input  logic [DAT_W-1:0] cpu_din,
  output logic             cpu_busy,
  output logic [REG_W-1:0] psg_addr,
  output logic [DAT_W-1:0] psg_din,
  output logic             psg_wr_n,
  output logic             busy,
  output logic             done
);

  localparam int CW = DAT_W + WAIT_SH;

  state_e        state_q, state_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  cmd_t          psg_q, psg_d;
  logic          psg_wr_n_q, psg_wr_n_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  cmd_t          slot_q, slot_d;
  logic          slot_vld_q, slot_vld_d;

  cmd_t          cmd;
  logic          cpu_strobe, cpu_issue, cpu_hold;
  logic          wait_load, wait_expire;
  logic [CW-1:0] wait_value;

  assign cmd        = cmd_t'(rom_data);
  assign wait_value = CW'(cmd.data) << WAIT_SH;
  assign cpu_strobe = !cpu_wr_n;
  // A pending slot goes out unless it is being overwritten or stop blanks the bus.
  assign cpu_issue  = slot_vld_q && cpu_wr_n && !stop;
  // The sequencer yields while a CPU write is arriving or still queued.
  assign cpu_hold   = cpu_strobe || slot_vld_q;

  jt49_seq_wait #(.W(CW)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (wait_load),
    .value (wait_value),
    .cen   (cen),
    .expire(wait_expire)
  );

  // Next-state logic: CPU slot, bus arbitration and sequencer FSM.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    psg_d      = psg_q;
    psg_wr_n_d = 1'b1;
    done_d     = 1'b0;
    slot_d     = slot_q;
    slot_vld_d = slot_vld_q;
    wait_load  = 1'b0;

    if (cpu_strobe) begin
      slot_d     = '{addr: cpu_addr, data: cpu_din};
      slot_vld_d = 1'b1;
    end else if (cpu_issue) begin
      slot_vld_d = 1'b0;
    end

    if (cpu_issue) begin
      psg_d      = slot_q;
      psg_wr_n_d = 1'b0;
    end

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rom_addr_d = '0;
            state_d    = ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_DECODE;
        ST_DECODE: begin
          if (cmd.addr == OP_END) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (cmd.addr == OP_WAIT) begin
            wait_load  = 1'b1;
            rom_addr_d = rom_addr_q + AW'(1);
            state_d    = (wait_value == '0) ? ST_FETCH : ST_WAIT;
          end else if (!cpu_hold) begin
            psg_d      = cmd;
            psg_wr_n_d = 1'b0;
            rom_addr_d = rom_addr_q + AW'(1);
            state_d    = ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (wait_expire) state_d = ST_FETCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      psg_q      <= '0;
      psg_wr_n_q <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      psg_q      <= psg_d;
      psg_wr_n_q <= psg_wr_n_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      slot_q     <= slot_d;
      slot_vld_q <= slot_vld_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign psg_addr = psg_q.addr;
  assign psg_din  = psg_q.data;
  assign psg_wr_n = psg_wr_n_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign cpu_busy = slot_vld_q;

endmodule

// File: tb/tb_jt49_seq.sv
// Self-checking bench for jt49_seq: directed scenarios plus random command
// programs, checked against a timeline model of the command rules.
module tb_jt49_seq;

  localparam int AW      = 6;
  localparam int WAIT_SH = 8;

  typedef struct {
    int         t;
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, cen, start, stop, cpu_wr_n;
  logic [3:0]    cpu_addr;
  logic [7:0]    cpu_din;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data;
  logic          cpu_busy, psg_wr_n, busy, done;
  logic [3:0]    psg_addr;
  logic [7:0]    psg_din;
  logic [11:0]   rom [64];

  logic          start2, stop2, cpu_wr_n2;
  logic [1:0]    rom_addr2;
  logic [11:0]   rom_data2;
  logic          cpu_busy2, psg_wr_n2, busy2, done2;
  logic [3:0]    psg_addr2;
  logic [7:0]    psg_din2;
  logic [11:0]   rom2 [4];

  // Synchronous command ROMs: data valid one cycle after the address.
  always @(posedge clk) rom_data  <= rom[rom_addr];
  always @(posedge clk) rom_data2 <= rom2[rom_addr2];

  jt49_seq #(.AW(AW), .WAIT_SH(WAIT_SH)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .stop(stop),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .cpu_wr_n(cpu_wr_n), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_busy(cpu_busy),
    .psg_addr(psg_addr), .psg_din(psg_din), .psg_wr_n(psg_wr_n),
    .busy(busy), .done(done)
  );

  jt49_seq #(.AW(2), .WAIT_SH(WAIT_SH)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start2), .stop(stop2),
    .rom_addr(rom_addr2), .rom_data(rom_data2),
    .cpu_wr_n(cpu_wr_n2), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_busy(cpu_busy2),
    .psg_addr(psg_addr2), .psg_din(psg_din2), .psg_wr_n(psg_wr_n2),
    .busy(busy2), .done(done2)
  );

  int  cyc = 0;
  int  n_vec = 0;
  int  n_fail = 0;
  int  cpu_busy_cycles = 0;
  wr_t obs[$], obs2[$], exp_q[$];
  int  done_t[$];
  bit  cen_tab [65536];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock: drive cen for the current cycle, then record bus activity after the edge.
  task automatic step();
    wr_t w;
    cen = cen_tab[cyc & 16'hFFFF];
    @(posedge clk);
    #1;
    cyc++;
    if (psg_wr_n === 1'b0) begin
      w.t = cyc; w.a = psg_addr; w.d = psg_din;
      obs.push_back(w);
    end
    if (psg_wr_n2 === 1'b0) begin
      w.t = cyc; w.a = psg_addr2; w.d = psg_din2;
      obs2.push_back(w);
    end
    if (done === 1'b1) done_t.push_back(cyc);
    if (cpu_busy === 1'b1) cpu_busy_cycles++;
  endtask

  // cen pattern: 0 = always high, 1 = every other cycle, 2 = random.
  task automatic fill_cen(input int mode);
    for (int i = 0; i < 65536; i++) begin
      case (mode)
        0:       cen_tab[i] = 1'b1;
        1:       cen_tab[i] = (i % 2) == 1;
        default: cen_tab[i] = $urandom_range(1, 0) == 1;
      endcase
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 12'hE00;
  endtask

  // Reference timeline. s is the first cycle spent fetching address 0.
  // A write is seen on the bus two cycles after its fetch and the next fetch
  // follows it; a wait of n pulses counts cen from two cycles after its fetch
  // and the next fetch comes the cycle after the last pulse; end pulses done
  // two cycles after its fetch.
  task automatic model(input int s, output int done_at);
    int          f, a, c, n, need;
    logic [11:0] cmd;
    wr_t         w;
    exp_q.delete();
    f = s; a = 0; done_at = -1;
    for (int k = 0; k < 200; k++) begin
      cmd = rom[a];
      if (cmd[11:8] == 4'hE) begin
        done_at = f + 2;
        break;
      end else if (cmd[11:8] == 4'hF) begin
        need = int'(cmd[7:0]) * (1 << WAIT_SH);
        if (need == 0) begin
          f = f + 2;
        end else begin
          c = f + 1; n = 0;
          while (n < need) begin
            c++;
            if (cen_tab[c & 16'hFFFF]) n++;
          end
          f = c + 1;
        end
      end else begin
        w.t = f + 2; w.a = cmd[11:8]; w.d = cmd[7:0];
        exp_q.push_back(w);
        f = f + 2;
      end
      a = (a + 1) % 64;
    end
  endtask

  // Start the loaded program, run it to its end and compare with the model.
  task automatic run_prog(input string tag, output int s);
    int dat, lim, nmin;
    obs.delete(); done_t.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    s = cyc;
    model(s, dat);
    lim = (dat > 0) ? dat + 4 : s + 200;
    while (cyc < lim) step();
    check({tag, " write count"}, obs.size(), exp_q.size());
    nmin = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      check($sformatf("%s wr%0d time", tag, i), obs[i].t - s, exp_q[i].t - s);
      check($sformatf("%s wr%0d addr/data", tag, i), {obs[i].a, obs[i].d}, {exp_q[i].a, exp_q[i].d});
    end
    check({tag, " done count"}, done_t.size(), 1);
    if (done_t.size() > 0) check({tag, " done time"}, done_t[0] - s, dat - s);
    check({tag, " busy low after end"}, busy, 1'b0);
  endtask

  initial begin
    int s, k, len;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cpu_wr_n = 1'b1;
    cpu_addr = '0; cpu_din = '0; cen = 1'b1;
    start2 = 1'b0; stop2 = 1'b0; cpu_wr_n2 = 1'b1;
    clear_rom();
    for (int i = 0; i < 4; i++) rom2[i] = 12'hE00;
    fill_cen(0);

    // Reset values.
    repeat (3) step();
    check("reset rom_addr", rom_addr, 0);
    check("reset psg_addr", psg_addr, 0);
    check("reset psg_din", psg_din, 0);
    check("reset psg_wr_n", psg_wr_n, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset cpu_busy", cpu_busy, 0);
    rst_n = 1'b1;
    step();

    // Two writes then end.
    clear_rom();
    rom[0] = 12'h011; rom[1] = 12'h102; rom[2] = 12'hE00;
    run_prog("t1", s);
    if (obs.size() == 2) check("t1 write spacing", obs[1].t - obs[0].t, 2);

    // Zero-length wait.
    clear_rom();
    rom[0] = 12'hF00; rom[1] = 12'h155; rom[2] = 12'hE00;
    run_prog("t5", s);
    if (obs.size() > 0) check("t5 zero wait write time", obs[0].t - s, 4);

    // CPU strobe while the sequencer decodes a write.
    clear_rom();
    rom[0] = 12'h0AA; rom[1] = 12'hE00;
    obs.delete(); done_t.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    s = cyc;
    step();
    cpu_wr_n = 1'b0; cpu_addr = 4'h8; cpu_din = 8'h10;
    cpu_busy_cycles = 0;
    step();
    cpu_wr_n = 1'b1;
    repeat (8) step();
    check("t3 write count", obs.size(), 2);
    if (obs.size() == 2) begin
      check("t3 cpu write time", obs[0].t - s, 3);
      check("t3 cpu write addr/data", {obs[0].a, obs[0].d}, 12'h810);
      check("t3 seq write time", obs[1].t - s, 4);
      check("t3 seq write addr/data", {obs[1].a, obs[1].d}, 12'h0AA);
    end
    check("t3 cpu_busy cycles", cpu_busy_cycles, 1);
    check("t3 done count", done_t.size(), 1);
    if (done_t.size() > 0) check("t3 done time", done_t[0] - s, 6);

    // CPU write while idle.
    obs.delete();
    cpu_wr_n = 1'b0; cpu_addr = 4'h3; cpu_din = 8'h5A;
    k = cyc;
    step();
    cpu_wr_n = 1'b1;
    repeat (3) step();
    check("idle cpu write count", obs.size(), 1);
    if (obs.size() == 1) begin
      check("idle cpu write time", obs[0].t - k, 2);
      check("idle cpu write addr/data", {obs[0].a, obs[0].d}, 12'h35A);
    end

    // 512-pulse wait with cen every other cycle.
    fill_cen(1);
    clear_rom();
    rom[0] = 12'hF02; rom[1] = 12'h7F8; rom[2] = 12'hE00;
    run_prog("t2", s);
    if (obs.size() == 1) check("t2 write after wait", obs[0].t - s >= 1026, 1);

    // Random programs ending in an end opcode.
    for (int r = 0; r < 6; r++) begin
      fill_cen(r % 3);
      clear_rom();
      len = 3 + int'($urandom_range(5, 0));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(3, 0) == 0) rom[i] = {4'hF, 7'd0, 1'($urandom_range(1, 0))};
        else rom[i] = {4'($urandom_range(13, 0)), 8'($urandom_range(255, 0))};
      end
      rom[len] = 12'hE00;
      run_prog($sformatf("rand%0d", r), s);
    end

    // Stop during a long wait, then replay from address 0.
    fill_cen(0);
    clear_rom();
    rom[0] = 12'h011; rom[1] = 12'hFFF; rom[2] = 12'hE00;
    obs.delete(); done_t.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t4 busy after stop", busy, 0);
    check("t4 psg_wr_n after stop", psg_wr_n, 1);
    check("t4 done after stop", done, 0);
    check("t4 rom_addr kept", rom_addr, 2);
    obs.delete(); done_t.delete();
    repeat (100) step();
    check("t4 writes after stop", obs.size(), 0);
    check("t4 done after stop count", done_t.size(), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    s = cyc;
    repeat (4) step();
    check("t4 replay write count", obs.size(), 1);
    if (obs.size() == 1) begin
      check("t4 replay write time", obs[0].t - s, 2);
      check("t4 replay addr/data", {obs[0].a, obs[0].d}, 12'h011);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();

    // Small ROM without end opcode wraps; reset lands mid-write.
    rom2[0] = 12'h001; rom2[1] = 12'h102; rom2[2] = 12'h203; rom2[3] = 12'h304;
    obs2.delete();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    s = cyc;
    repeat (20) step();
    check("t6 write count", obs2.size() >= 8, 1);
    for (int i = 0; i < 8 && i < obs2.size(); i++) begin
      check($sformatf("t6 wr%0d time", i), obs2[i].t - s, 2 + 2 * i);
      check($sformatf("t6 wr%0d addr/data", i), {obs2[i].a, obs2[i].d}, {4'(i % 4), 8'(i % 4 + 1)});
    end
    for (int i = 0; i < 4 && psg_wr_n2 !== 1'b0; i++) step();
    check("t6 mid-write reached", psg_wr_n2, 0);
    rst_n = 1'b0;
    step();
    check("t6 reset rom_addr", rom_addr2, 0);
    check("t6 reset psg_addr", psg_addr2, 0);
    check("t6 reset psg_din", psg_din2, 0);
    check("t6 reset psg_wr_n", psg_wr_n2, 1);
    check("t6 reset busy", busy2, 0);
    check("t6 reset done", done2, 0);
    check("t6 reset cpu_busy", cpu_busy2, 0);
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
